// File: rtl/rename_regfile_pkg.sv
// Shared defaults and index/tag/data types for the rename register file.
package rename_regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_REG_W = $clog2(DEF_NREG);
    localparam int DEF_ROB_W = 4;

    typedef logic [DEF_REG_W-1:0] reg_idx_t;
    typedef logic [DEF_ROB_W-1:0] rob_tag_t;
    typedef logic [DEF_XLEN-1:0]  xlen_t;
endpackage

// File: rtl/rename_regfile_rdport.sv
// One combinational source-operand read port: stored state, earlier-slot renames and commit bypass.
module rename_regfile_rdport
    import rename_regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int ROB_W    = DEF_ROB_W,
    parameter int DISP_W   = 2,
    parameter int COMMIT_W = 2,
    parameter int SLOT     = 0,
    localparam int REG_W   = $clog2(NREG)
) (
    input  logic [REG_W-1:0]                   idx,
    input  logic                               bypass,
    input  logic [NREG-1:0]                    busy_q,
    input  logic [NREG-1:0][XLEN-1:0]          value_q,
    input  logic [NREG-1:0][ROB_W-1:0]         tag_q,
    input  logic [DISP_W-1:0]                  ren_en,
    input  logic [DISP_W-1:0][REG_W-1:0]       ren_rd,
    input  logic [DISP_W-1:0][ROB_W-1:0]       ren_tag,
    input  logic [COMMIT_W-1:0]                commit_en,
    input  logic [COMMIT_W-1:0][REG_W-1:0]     commit_rd,
    input  logic [COMMIT_W-1:0][XLEN-1:0]      commit_value,
    input  logic [COMMIT_W-1:0][ROB_W-1:0]     commit_tag,
    output logic                               busy,
    output logic [XLEN-1:0]                    value,
    output logic [ROB_W-1:0]                   tag
);
    logic             ren_hit;
    logic [ROB_W-1:0] ren_hit_tag;
    logic             retired;

    always_comb begin
        busy        = 1'b0;
        value       = '0;
        tag         = '0;
        ren_hit     = 1'b0;
        ren_hit_tag = '0;
        retired     = 1'b0;
        if (idx != '0) begin
            // Later slots in the loop overwrite earlier ones, so the nearest older rename wins
            for (int j = 0; j < DISP_W; j++) begin
                if (bypass && (j < SLOT) && ren_en[j] && (ren_rd[j] == idx)) begin
                    ren_hit     = 1'b1;
                    ren_hit_tag = ren_tag[j];
                end
            end
            if (ren_hit) begin
                busy = 1'b1;
                tag  = ren_hit_tag;
            end else begin
                value = value_q[idx];
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (bypass && commit_en[k] && (commit_rd[k] == idx)) begin
                        value = commit_value[k];
                        if (commit_tag[k] == tag_q[idx])
                            retired = 1'b1;
                    end
                end
                busy = busy_q[idx] && !retired;
                tag  = busy ? tag_q[idx] : '0;
            end
        end
    end
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/tag rename status, commit bypass and flush.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int ROB_W    = DEF_ROB_W,
    parameter int DISP_W   = 2,
    parameter int COMMIT_W = 2,
    localparam int REG_W   = $clog2(NREG)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        rdy_in,
    input  logic [DISP_W*REG_W-1:0]     disp_rs_in,
    input  logic [DISP_W*REG_W-1:0]     disp_rt_in,
    output logic [DISP_W-1:0]           rs_busy_out,
    output logic [DISP_W-1:0]           rt_busy_out,
    output logic [DISP_W*XLEN-1:0]      rs_value_out,
    output logic [DISP_W*XLEN-1:0]      rt_value_out,
    output logic [DISP_W*ROB_W-1:0]     rs_tag_out,
    output logic [DISP_W*ROB_W-1:0]     rt_tag_out,
    input  logic [DISP_W-1:0]           disp_rd_en_in,
    input  logic [DISP_W*REG_W-1:0]     disp_rd_in,
    input  logic [DISP_W*ROB_W-1:0]     disp_tag_in,
    input  logic [COMMIT_W-1:0]         commit_en_in,
    input  logic [COMMIT_W*REG_W-1:0]   commit_rd_in,
    input  logic [COMMIT_W*XLEN-1:0]    commit_value_in,
    input  logic [COMMIT_W*ROB_W-1:0]   commit_tag_in,
    input  logic                        flush_in
);
    logic [NREG-1:0]                busy_q;
    logic [NREG-1:0][XLEN-1:0]      value_q;
    logic [NREG-1:0][ROB_W-1:0]     tag_q;

    logic [DISP_W-1:0][REG_W-1:0]   ren_rd;
    logic [DISP_W-1:0][ROB_W-1:0]   ren_tag;
    logic [COMMIT_W-1:0][REG_W-1:0] commit_rd;
    logic [COMMIT_W-1:0][XLEN-1:0]  commit_value;
    logic [COMMIT_W-1:0][ROB_W-1:0] commit_tag;

    logic                           bypass;
    logic [DISP_W-1:0]              rs_busy, rt_busy;
    logic [DISP_W-1:0][XLEN-1:0]    rs_value, rt_value;
    logic [DISP_W-1:0][ROB_W-1:0]   rs_tag, rt_tag;

    assign ren_rd       = disp_rd_in;
    assign ren_tag      = disp_tag_in;
    assign commit_rd    = commit_rd_in;
    assign commit_value = commit_value_in;
    assign commit_tag   = commit_tag_in;
    assign bypass       = rdy_in && !flush_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q  <= '0;
            value_q <= '0;
            tag_q   <= '0;
        end else if (rdy_in) begin
            // Commits compare against the pre-edge tag; later NBAs let higher slots and renames win
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_en_in[k] && (commit_rd[k] != '0)) begin
                    value_q[commit_rd[k]] <= commit_value[k];
                    if (commit_tag[k] == tag_q[commit_rd[k]]) begin
                        busy_q[commit_rd[k]] <= 1'b0;
                        tag_q[commit_rd[k]]  <= '0;
                    end
                end
            end
            if (flush_in) begin
                busy_q <= '0;
                tag_q  <= '0;
            end else begin
                for (int s = 0; s < DISP_W; s++) begin
                    if (disp_rd_en_in[s] && (ren_rd[s] != '0)) begin
                        busy_q[ren_rd[s]] <= 1'b1;
                        tag_q[ren_rd[s]]  <= ren_tag[s];
                    end
                end
            end
        end
    end

    for (genvar s = 0; s < DISP_W; s++) begin : g_slot
        rename_regfile_rdport #(
            .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
            .DISP_W(DISP_W), .COMMIT_W(COMMIT_W), .SLOT(s)
        ) u_rs (
            .idx(disp_rs_in[s*REG_W +: REG_W]), .bypass(bypass),
            .busy_q(busy_q), .value_q(value_q), .tag_q(tag_q),
            .ren_en(disp_rd_en_in), .ren_rd(ren_rd), .ren_tag(ren_tag),
            .commit_en(commit_en_in), .commit_rd(commit_rd),
            .commit_value(commit_value), .commit_tag(commit_tag),
            .busy(rs_busy[s]), .value(rs_value[s]), .tag(rs_tag[s])
        );
        rename_regfile_rdport #(
            .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
            .DISP_W(DISP_W), .COMMIT_W(COMMIT_W), .SLOT(s)
        ) u_rt (
            .idx(disp_rt_in[s*REG_W +: REG_W]), .bypass(bypass),
            .busy_q(busy_q), .value_q(value_q), .tag_q(tag_q),
            .ren_en(disp_rd_en_in), .ren_rd(ren_rd), .ren_tag(ren_tag),
            .commit_en(commit_en_in), .commit_rd(commit_rd),
            .commit_value(commit_value), .commit_tag(commit_tag),
            .busy(rt_busy[s]), .value(rt_value[s]), .tag(rt_tag[s])
        );
    end

    // Bypassed commit data must not leak out while reset is held
    assign rs_busy_out  = rst_n_in ? rs_busy  : '0;
    assign rt_busy_out  = rst_n_in ? rt_busy  : '0;
    assign rs_value_out = rst_n_in ? rs_value : '0;
    assign rt_value_out = rst_n_in ? rt_value : '0;
    assign rs_tag_out   = rst_n_in ? rs_tag   : '0;
    assign rt_tag_out   = rst_n_in ? rt_tag   : '0;
endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expected reads are queued as stimulus is driven, then compared.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    localparam int XLEN = 32, NREG = 32, REG_W = 5, ROB_W = 4, DISP_W = 2, COMMIT_W = 2;

    logic                      clk_in = 1'b0;
    logic                      rst_n_in;
    logic                      rdy_in;
    logic [DISP_W*REG_W-1:0]   disp_rs_in, disp_rt_in;
    logic [DISP_W-1:0]         rs_busy_out, rt_busy_out;
    logic [DISP_W*XLEN-1:0]    rs_value_out, rt_value_out;
    logic [DISP_W*ROB_W-1:0]   rs_tag_out, rt_tag_out;
    logic [DISP_W-1:0]         disp_rd_en_in;
    logic [DISP_W*REG_W-1:0]   disp_rd_in;
    logic [DISP_W*ROB_W-1:0]   disp_tag_in;
    logic [COMMIT_W-1:0]       commit_en_in;
    logic [COMMIT_W*REG_W-1:0] commit_rd_in;
    logic [COMMIT_W*XLEN-1:0]  commit_value_in;
    logic [COMMIT_W*ROB_W-1:0] commit_tag_in;
    logic                      flush_in;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        int          slot;
        bit          rt;
        logic        busy;
        logic [31:0] value;
        logic [3:0]  tag;
        bit          chk_val;
        bit          chk_tag;
    } exp_t;
    exp_t sb[$];

    rename_regfile #(
        .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .DISP_W(DISP_W), .COMMIT_W(COMMIT_W)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .disp_rs_in(disp_rs_in), .disp_rt_in(disp_rt_in),
        .rs_busy_out(rs_busy_out), .rt_busy_out(rt_busy_out),
        .rs_value_out(rs_value_out), .rt_value_out(rt_value_out),
        .rs_tag_out(rs_tag_out), .rt_tag_out(rt_tag_out),
        .disp_rd_en_in(disp_rd_en_in), .disp_rd_in(disp_rd_in), .disp_tag_in(disp_tag_in),
        .commit_en_in(commit_en_in), .commit_rd_in(commit_rd_in),
        .commit_value_in(commit_value_in), .commit_tag_in(commit_tag_in),
        .flush_in(flush_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle();
        rdy_in          = 1'b1;
        flush_in        = 1'b0;
        disp_rs_in      = '0;
        disp_rt_in      = '0;
        disp_rd_en_in   = '0;
        disp_rd_in      = '0;
        disp_tag_in     = '0;
        commit_en_in    = '0;
        commit_rd_in    = '0;
        commit_value_in = '0;
        commit_tag_in   = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rd(input int s, input reg_idx_t rs, input reg_idx_t rt);
        disp_rs_in[s*REG_W +: REG_W] = rs;
        disp_rt_in[s*REG_W +: REG_W] = rt;
    endtask

    task automatic ren(input int s, input reg_idx_t r, input rob_tag_t t);
        disp_rd_en_in[s]              = 1'b1;
        disp_rd_in[s*REG_W +: REG_W]  = r;
        disp_tag_in[s*ROB_W +: ROB_W] = t;
    endtask

    task automatic cmt(input int k, input reg_idx_t r, input xlen_t v, input rob_tag_t t);
        commit_en_in[k]                 = 1'b1;
        commit_rd_in[k*REG_W +: REG_W]  = r;
        commit_value_in[k*XLEN +: XLEN] = v;
        commit_tag_in[k*ROB_W +: ROB_W] = t;
    endtask

    task automatic expect_rd(input string name, input int s, input bit rt, input logic busy,
                             input logic [31:0] value, input logic [3:0] tag,
                             input bit chk_val, input bit chk_tag);
        exp_t e;
        e.name = name; e.slot = s; e.rt = rt; e.busy = busy; e.value = value;
        e.tag = tag; e.chk_val = chk_val; e.chk_tag = chk_tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic        b;
        logic [31:0] v;
        logic [3:0]  t;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            b = e.rt ? rt_busy_out[e.slot] : rs_busy_out[e.slot];
            v = e.rt ? rt_value_out[e.slot*XLEN +: XLEN] : rs_value_out[e.slot*XLEN +: XLEN];
            t = e.rt ? rt_tag_out[e.slot*ROB_W +: ROB_W] : rs_tag_out[e.slot*ROB_W +: ROB_W];
            check_eq({e.name, ".busy"}, 32'(b), 32'(e.busy));
            if (e.chk_val) check_eq({e.name, ".value"}, v, e.value);
            if (e.chk_tag) check_eq({e.name, ".tag"}, 32'(t), 32'(e.tag));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n_in = 1'b0;
        #2;
        // Held in reset: commit to x5 must be invisible and outputs forced to 0
        cmt(0, 5, 32'hDEAD, 0);
        rd(0, 5, 5); rd(1, 5, 5);
        expect_rd("rst_s0_x5", 0, 0, 0, 0, 0, 1, 1);
        expect_rd("rst_s1_x5", 1, 0, 0, 0, 0, 1, 1);
        drain();
        step(); step();
        rst_n_in = 1'b1;
        idle();
        rd(0, 5, 5); rd(1, 5, 5);
        expect_rd("post_rst_s0_x5", 0, 1, 0, 0, 0, 1, 1);
        expect_rd("post_rst_s1_x5", 1, 1, 0, 0, 0, 1, 1);
        drain();
        ren(0, 3, 7);
        step();

        idle();
        rd(1, 3, 0);
        expect_rd("x3_renamed", 1, 0, 1, 0, 7, 0, 1);
        drain();
        step();

        idle();
        cmt(0, 3, 32'h1234, 7);
        rd(0, 3, 3);
        expect_rd("x3_commit_bypass", 0, 0, 0, 32'h1234, 0, 1, 0);
        drain();
        step();

        idle();
        rd(0, 3, 0);
        ren(0, 4, 2);
        rd(1, 4, 3);
        ren(1, 4, 3);
        expect_rd("x3_stored", 0, 0, 0, 32'h1234, 0, 1, 0);
        expect_rd("x4_intra_bundle", 1, 0, 1, 0, 2, 1, 1);
        expect_rd("x3_slot1_rt", 1, 1, 0, 32'h1234, 0, 1, 0);
        drain();
        step();

        idle();
        rd(0, 4, 0);
        ren(0, 6, 9);
        expect_rd("x4_last_slot_wins", 0, 0, 1, 0, 3, 0, 1);
        drain();
        step();

        idle();
        cmt(0, 6, 32'h55, 5);
        rd(0, 6, 0);
        expect_rd("x6_wrong_tag_bypass", 0, 0, 1, 32'h55, 9, 1, 1);
        drain();
        step();

        idle();
        rd(0, 6, 0);
        expect_rd("x6_wrong_tag_stored", 0, 0, 1, 32'h55, 9, 1, 1);
        drain();
        cmt(0, 6, 32'h11, 1);
        cmt(1, 6, 32'h22, 2);
        expect_rd("x6_dual_commit_bypass", 0, 0, 1, 32'h22, 9, 1, 1);
        drain();
        step();

        idle();
        rd(0, 6, 0);
        ren(0, 8, 4);
        ren(1, 9, 6);
        expect_rd("x6_dual_commit_stored", 0, 0, 1, 32'h22, 9, 1, 1);
        drain();
        step();

        idle();
        rd(0, 8, 9);
        expect_rd("x8_busy", 0, 0, 1, 0, 4, 0, 1);
        expect_rd("x9_busy", 0, 1, 1, 0, 6, 0, 1);
        drain();
        // Flush: reads see stored state only, even with a same-bundle rename and commit
        flush_in = 1'b1;
        cmt(0, 8, 32'hAA, 1);
        ren(0, 9, 12);
        rd(1, 9, 8);
        expect_rd("flush_x9_no_fwd", 1, 0, 1, 0, 6, 1, 1);
        expect_rd("flush_x8_no_bypass", 1, 1, 1, 0, 4, 1, 1);
        drain();
        step();

        idle();
        rd(0, 8, 9);
        rd(1, 6, 3);
        expect_rd("post_flush_x8", 0, 0, 0, 32'hAA, 0, 1, 0);
        expect_rd("post_flush_x9", 0, 1, 0, 0, 0, 0, 0);
        expect_rd("post_flush_x6", 1, 0, 0, 32'h22, 0, 1, 0);
        expect_rd("post_flush_x3", 1, 1, 0, 32'h1234, 0, 1, 0);
        drain();
        step();

        idle();
        rdy_in = 1'b0;
        cmt(0, 2, 32'd7, 0);
        ren(0, 2, 5);
        rd(0, 2, 0);
        rd(1, 2, 0);
        expect_rd("stall_x2_s0", 0, 0, 0, 0, 0, 1, 0);
        expect_rd("stall_x2_s1", 1, 0, 0, 0, 0, 1, 0);
        drain();
        step();

        idle();
        rd(0, 2, 0);
        ren(0, 0, 3);
        cmt(0, 0, 32'd5, 0);
        rd(1, 0, 0);
        expect_rd("post_stall_x2", 0, 0, 0, 0, 0, 1, 0);
        expect_rd("x0_rename_fwd", 1, 0, 0, 0, 0, 1, 1);
        drain();
        step();

        idle();
        rd(0, 0, 0);
        cmt(0, 10, 32'h77, 0);
        expect_rd("x0_stored", 0, 0, 0, 0, 0, 1, 1);
        drain();
        step();

        idle();
        rd(0, 10, 0);
        expect_rd("x10_stored", 0, 0, 0, 32'h77, 0, 1, 0);
        drain();
        // Reset pulse between clock edges must clear state without an edge
        #1;
        rst_n_in = 1'b0;
        expect_rd("async_rst_forced", 0, 0, 0, 0, 0, 1, 1);
        drain();
        rst_n_in = 1'b1;
        expect_rd("async_rst_cleared", 0, 0, 0, 0, 0, 1, 0);
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
